// File: rtl/interp_sched_pkg.sv
// Shared types and helpers for the interpolation-chain rate scheduler.
package interp_sched_pkg;

    localparam int DATA_W_DEF = 24;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        RUN        = 2'd2,
        FLUSH      = 2'd3
    } sched_state_t;

    // Width of a counter that must hold 0..periods-1.
    function automatic int flush_cnt_w(input int periods);
        return (periods > 1) ? $clog2(periods) : 1;
    endfunction

endpackage

// File: rtl/interp_phase_gen.sv
// Phase counter over one input period plus registered per-stage strobe decode.
// count_en high means the following cycle is a counting cycle; the first such cycle shows phase 0.
module interp_phase_gen #(
    parameter int NUM_STAGES = 3,
    parameter int BASE_DIV   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  count_en,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic                  wrap
);

    localparam int PW = $clog2(BASE_DIV);

    logic [PW-1:0] phase_cnt;
    logic [PW-1:0] phase_next;
    logic          running;

    function automatic logic [NUM_STAGES-1:0] decode_strobes(input logic [PW-1:0] p);
        logic [NUM_STAGES-1:0] s;
        s = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            s[k] = ((p & PW'((BASE_DIV >> k) - 1)) == '0);
        end
        return s;
    endfunction

    // BASE_DIV is a power of two, so the natural PW-bit overflow is the period wrap.
    assign phase_next = running ? (phase_cnt + 1'b1) : '0;
    assign wrap       = running && (phase_cnt == PW'(BASE_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || !count_en) begin
            phase_cnt <= '0;
            stage_en  <= '0;
            running   <= 1'b0;
        end else begin
            phase_cnt <= phase_next;
            stage_en  <= decode_strobes(phase_next);
            running   <= 1'b1;
        end
    end

endmodule

// File: rtl/interp_enable_sched.sv
// Rate scheduler feeding the cascaded x2 interpolation chain: handshake, one-entry buffer, stage strobes.
// Optional INTERP_SCHED_STATS_EN adds a 16-bit saturating underrun counter port.
import interp_sched_pkg::*;

module interp_enable_sched #(
    parameter int DATA_W        = DATA_W_DEF,
    parameter int NUM_STAGES    = 3,
    parameter int BASE_DIV      = 64,
    parameter int FLUSH_PERIODS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] pcm_out,
    output logic [NUM_STAGES-1:0]    stage_en,
    output logic                     busy,
    output logic                     underrun
`ifdef INTERP_SCHED_STATS_EN
    ,
    output logic [15:0]              underrun_cnt
`endif
);

    localparam int FCW = flush_cnt_w(FLUSH_PERIODS);

    sched_state_t             state;
    logic signed [DATA_W-1:0] buf_data;
    logic                     buf_full;
    logic [FCW-1:0]           flush_cnt;
    logic                     wrap;
    logic                     accept;
    logic                     count_en;
    logic                     flush_last;
    logic                     underrun_evt;

    assign in_ready     = (state == WAIT_FIRST) || ((state == RUN) && (!buf_full || wrap));
    assign accept       = in_valid && in_ready;
    assign flush_last   = (flush_cnt == FCW'(FLUSH_PERIODS - 1));
    // Period boundary while streaming with nothing buffered and nothing arriving.
    assign underrun_evt = (state == RUN) && wrap && run && !buf_full && !accept;

    always_comb begin
        count_en = 1'b0;
        case (state)
            WAIT_FIRST: count_en = in_valid;
            RUN:        count_en = 1'b1;
            FLUSH:      count_en = !(wrap && flush_last);
            default:    count_en = 1'b0;
        endcase
    end

    interp_phase_gen #(
        .NUM_STAGES (NUM_STAGES),
        .BASE_DIV   (BASE_DIV)
    ) u_phase_gen (
        .clk      (clk),
        .rst      (rst),
        .count_en (count_en),
        .stage_en (stage_en),
        .wrap     (wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            buf_full  <= 1'b0;
            pcm_out   <= '0;
            underrun  <= 1'b0;
            flush_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state    <= WAIT_FIRST;
                        busy     <= 1'b1;
                        underrun <= 1'b0;
                    end
                end
                WAIT_FIRST: begin
                    // A sample already offered is taken in preference to abandoning start-up.
                    if (accept) begin
                        pcm_out  <= in_data;
                        buf_full <= 1'b0;
                        state    <= RUN;
                    end else if (!run) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    if (wrap && !run) begin
                        state     <= FLUSH;
                        pcm_out   <= '0;
                        buf_full  <= 1'b0;
                        flush_cnt <= '0;
                    end else if (wrap) begin
                        if (buf_full) begin
                            pcm_out  <= buf_data;
                            buf_full <= accept;
                            if (accept) begin
                                buf_data <= in_data;
                            end
                        end else if (accept) begin
                            pcm_out <= in_data;
                        end else begin
                            pcm_out <= '0;
                        end
                        if (underrun_evt) begin
                            underrun <= 1'b1;
                        end
                    end else if (accept) begin
                        buf_data <= in_data;
                        buf_full <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (wrap) begin
                        if (flush_last) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            flush_cnt <= flush_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef INTERP_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || ((state == IDLE) && run)) begin
            underrun_cnt <= '0;
        end else if (underrun_evt && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule
